mult_share_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one registered unsigned multiplier (product width 2*DW) between NREQ requesters. Each requester gets a valid/ready request channel and a private one-entry response slot with its own valid/ready. The block pipelines operands into the multiplier and routes each product back to the requester that issued it. It sits between the requesting datapath units and the single multiplier instance, which it instantiates internally.

---
 rtl/mult_share_arb_if.sv | 24 ++
 rtl/mult_share_arb.sv | 157 +++++++++++++++
 tb/tb_mult_share_arb.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_share_arb_if.sv
// Request/response bundle between NREQ requesters and the shared-multiplier arbiter.
// Operands and products are packed per requester: requester k owns slice [k*W +: W].
interface mult_share_arb_if #(
    parameter int NREQ = 4,
    parameter int DW   = 16
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*DW-1:0]     req_i0;
    logic [NREQ*DW-1:0]     req_i1;
    logic [NREQ-1:0]        rsp_valid;
    logic [NREQ-1:0]        rsp_ready;
    logic [NREQ*2*DW-1:0]   rsp_data;

    modport master (
        output req_valid, req_i0, req_i1, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_i0, req_i1, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/mult_share_arb.sv
// Round-robin arbiter feeding one registered unsigned multiplier shared by NREQ requesters.
// Defining MULT_ARB_STATS_EN builds the saturating accepted-operation counter on stat_ops.
module mult_share_arb #(
    parameter int NREQ = 4,
    parameter int DW   = 16
) (
    input  logic               clk,
    input  logic               rst,
    mult_share_arb_if.slave    bus,
    output logic               busy,
    output logic [31:0]        stat_ops
);
    localparam int IW = $clog2(NREQ);
    localparam int PW = 2 * DW;

    logic [IW-1:0]      last_q;
    logic               s1_valid_q;
    logic [IW-1:0]      s1_owner_q;
    logic [DW-1:0]      s1_a_q;
    logic [DW-1:0]      s1_b_q;
    logic               s2_valid_q;
    logic [IW-1:0]      s2_owner_q;
    logic [PW-1:0]      s2_prod_q;
    logic [NREQ-1:0]    rsp_valid_q;
    logic [NREQ-1:0]    rsp_valid_d;
    logic [PW-1:0]      slot_q [NREQ];

    logic [NREQ-1:0]    elig;
    logic [NREQ-1:0]    drain;
    logic [NREQ-1:0]    grant;
    logic               grant_any;
    logic [IW-1:0]      grant_idx;
    logic [IW-1:0]      cand;
    logic [NREQ*PW-1:0] rsp_data_flat;

    // A requester with an op in S1/S2 is held off, which keeps one op outstanding per slot.
    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            drain[k] = rsp_valid_q[k] && bus.rsp_ready[k];
            elig[k]  = bus.req_valid[k]
                    && !(s1_valid_q && (s1_owner_q == IW'(k)))
                    && !(s2_valid_q && (s2_owner_q == IW'(k)))
                    && (!rsp_valid_q[k] || bus.rsp_ready[k]);
        end
    end

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        grant     = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IW'((int'(last_q) + i) % NREQ);
            if (!grant_any && elig[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        if (rst) begin
            grant_any = 1'b0;
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // A slot write and a drain cannot coincide, so the write simply takes precedence.
    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            rsp_valid_d[k] = rsp_valid_q[k];
            if (drain[k]) begin
                rsp_valid_d[k] = 1'b0;
            end
            if (s2_valid_q && (s2_owner_q == IW'(k))) begin
                rsp_valid_d[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q      <= IW'(NREQ - 1);
            s1_valid_q  <= 1'b0;
            s1_owner_q  <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_owner_q  <= '0;
            s2_prod_q   <= '0;
            rsp_valid_q <= '0;
            for (int k = 0; k < NREQ; k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            s1_valid_q <= grant_any;
            if (grant_any) begin
                last_q     <= grant_idx;
                s1_owner_q <= grant_idx;
                s1_a_q     <= bus.req_i0[grant_idx*DW +: DW];
                s1_b_q     <= bus.req_i1[grant_idx*DW +: DW];
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_owner_q <= s1_owner_q;
                s2_prod_q  <= PW'(s1_a_q) * PW'(s1_b_q);
            end
            rsp_valid_q <= rsp_valid_d;
            for (int k = 0; k < NREQ; k++) begin
                if (s2_valid_q && (s2_owner_q == IW'(k))) begin
                    slot_q[k] <= s2_prod_q;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(s2_valid_q && drain[s2_owner_q]));
        end
    end

    always_comb begin
        rsp_data_flat = '0;
        for (int k = 0; k < NREQ; k++) begin
            rsp_data_flat[k*PW +: PW] = slot_q[k];
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_flat;
    assign busy          = s1_valid_q | s2_valid_q;

`ifdef MULT_ARB_STATS_EN
    logic [31:0] stat_ops_q;
    logic [31:0] stat_ops_d;

    always_comb begin
        stat_ops_d = stat_ops_q;
        if (grant_any && (stat_ops_q != 32'hFFFF_FFFF)) begin
            stat_ops_d = stat_ops_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops_q <= '0;
        end else begin
            stat_ops_q <= stat_ops_d;
        end
    end

    assign stat_ops = stat_ops_q;
`else
    assign stat_ops = '0;
`endif
endmodule

// File: tb/tb_mult_share_arb.sv
// Self-checking bench for mult_share_arb: directed scenarios followed by random traffic,
// all compared every cycle against a per-requester behavioural model of the arbiter.
module tb_mult_share_arb;
    localparam int NREQ = 4;
    localparam int DW   = 16;
    localparam int PW   = 2 * DW;

    logic        clk = 1'b0;
    logic        rst;
    logic        busy;
    logic [31:0] statOps;

    mult_share_arb_if #(.NREQ(NREQ), .DW(DW)) bus ();

    mult_share_arb #(.NREQ(NREQ), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .stat_ops (statOps)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: each requester is idle, has an op due at a known edge, and/or holds a full slot.
    int              lastM;
    bit              pendM [NREQ];
    int              dueM  [NREQ];
    logic [PW-1:0]   prodM [NREQ];
    bit              fullM [NREQ];
    logic [PW-1:0]   dataM [NREQ];
    int              cycM;
    int              acceptsM;
    logic [NREQ-1:0] lastReady;

    task automatic checkVal(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NREQ-1:0] modelGrant();
        logic [NREQ-1:0] g;
        int idx;
        g = '0;
        if (rst) return g;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (lastM + i) % NREQ;
            if (bus.req_valid[idx] && !pendM[idx] && (!fullM[idx] || bus.rsp_ready[idx])) begin
                g[idx] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    task automatic modelReset();
        lastM    = NREQ - 1;
        acceptsM = 0;
        for (int k = 0; k < NREQ; k++) begin
            pendM[k] = 1'b0;
            dueM[k]  = 0;
            prodM[k] = '0;
            fullM[k] = 1'b0;
            dataM[k] = '0;
        end
    endtask

    task automatic modelUpdate();
        logic [NREQ-1:0] g;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        g = modelGrant();
        cycM++;
        if (rst) begin
            modelReset();
            return;
        end
        for (int k = 0; k < NREQ; k++) begin
            if (fullM[k] && bus.rsp_ready[k]) fullM[k] = 1'b0;
        end
        for (int k = 0; k < NREQ; k++) begin
            if (pendM[k] && dueM[k] == cycM) begin
                fullM[k] = 1'b1;
                dataM[k] = prodM[k];
                pendM[k] = 1'b0;
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (g[k]) begin
                a = bus.req_i0[k*DW +: DW];
                b = bus.req_i1[k*DW +: DW];
                pendM[k] = 1'b1;
                dueM[k]  = cycM + 2;
                prodM[k] = PW'(a) * PW'(b);
                lastM    = k;
                acceptsM++;
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [NREQ-1:0]    expValid;
        logic [NREQ*PW-1:0] expData;
        bit                 expBusy;
        int                 expStats;
        expBusy = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            expValid[k]           = fullM[k];
            expData[k*PW +: PW]   = dataM[k];
            if (pendM[k]) expBusy = 1'b1;
        end
`ifdef MULT_ARB_STATS_EN
        expStats = acceptsM;
`else
        expStats = 0;
`endif
        checkVal({tag, ".req_ready"}, 128'(bus.req_ready), 128'(modelGrant()));
        checkVal({tag, ".rsp_valid"}, 128'(bus.rsp_valid), 128'(expValid));
        checkVal({tag, ".rsp_data"},  128'(bus.rsp_data),  128'(expData));
        checkVal({tag, ".busy"},      128'(busy),          128'(expBusy));
        checkVal({tag, ".stat_ops"},  128'(statOps),       128'(expStats));
        lastReady = bus.req_ready;
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic [NREQ-1:0] rrdy, input logic rstv);
        bus.req_valid = valid;
        bus.rsp_ready = rrdy;
        rst           = rstv;
    endtask

    task automatic setOps(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b);
        bus.req_i0[k*DW +: DW] = a;
        bus.req_i1[k*DW +: DW] = b;
    endtask

    task automatic randomOps();
        for (int k = 0; k < NREQ; k++) begin
            setOps(k, DW'($urandom), DW'($urandom));
        end
    endtask

    // One clock: check settled outputs against the model, take the edge, advance the model.
    task automatic stepCycle(input string tag);
        #1;
        checkOutput(tag);
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
    endtask

    initial begin
        int bpSeen;
        int acc;
        int guard;

        cycM = 0;
        bus.req_i0 = '0;
        bus.req_i1 = '0;
        applyStimulus('0, '1, 1'b1);
        modelReset();
        @(posedge clk);
        @(negedge clk);
        $display("[TB] reset");
        stepCycle("reset0");
        stepCycle("reset1");
        applyStimulus('0, '1, 1'b0);
        stepCycle("idle");

        $display("[TB] single op");
        setOps(2, 16'h00FF, 16'h0101);
        applyStimulus(4'b0100, 4'b1111, 1'b0);
        stepCycle("single.c0");
        checkVal("single.grant", 128'(lastReady), 128'(4'b0100));
        applyStimulus(4'b0000, 4'b1111, 1'b0);
        stepCycle("single.c1");
        checkVal("single.early", 128'(bus.rsp_valid[2]), 128'(1'b0));
        stepCycle("single.c2");
        checkVal("single.valid", 128'(bus.rsp_valid[2]), 128'(1'b1));
        checkVal("single.data", 128'(bus.rsp_data[2*PW +: PW]), 128'(32'h0000_FFFF));

        $display("[TB] max width");
        setOps(0, 16'hFFFF, 16'hFFFF);
        applyStimulus(4'b0001, 4'b1111, 1'b0);
        stepCycle("max.c0");
        checkVal("max.grant", 128'(lastReady), 128'(4'b0001));
        applyStimulus(4'b0000, 4'b1111, 1'b0);
        stepCycle("max.c1");
        stepCycle("max.c2");
        checkVal("max.data", 128'(bus.rsp_data[0 +: PW]), 128'(32'hFFFE_0001));

        $display("[TB] fairness");
        applyStimulus('0, '1, 1'b1);
        stepCycle("fair.rst");
        applyStimulus(4'b1111, 4'b1111, 1'b0);
        for (int i = 0; i < 12; i++) begin
            randomOps();
            stepCycle("fair");
            checkVal("fair.order", 128'(lastReady), 128'(4'b0001 << (i % NREQ)));
        end

        $display("[TB] backpressure");
        applyStimulus(4'b1111, 4'b1101, 1'b0);
        bpSeen = 0;
        for (int i = 0; i < 12; i++) begin
            randomOps();
            stepCycle("bp");
            if (fullM[1]) begin
                bpSeen++;
                checkVal("bp.hold1", 128'(lastReady[1]), 128'(1'b0));
            end
        end
        checkVal("bp.slotFull", 128'(bus.rsp_valid[1]), 128'(1'b1));
        applyStimulus(4'b0010, 4'b1111, 1'b0);
        stepCycle("bp.release");
        checkVal("bp.releaseGrant", 128'(lastReady), 128'(4'b0010));

        $display("[TB] reset mid-flight");
        applyStimulus('0, '1, 1'b1);
        stepCycle("mid.rst0");
        applyStimulus(4'b0001, 4'b1111, 1'b0);
        stepCycle("mid.acc0");
        applyStimulus(4'b0010, 4'b1111, 1'b0);
        stepCycle("mid.acc1");
        applyStimulus(4'b0000, 4'b1111, 1'b1);
        stepCycle("mid.rst");
        applyStimulus(4'b0000, 4'b1111, 1'b0);
        for (int i = 0; i < 4; i++) begin
            stepCycle("mid.after");
            checkVal("mid.noRsp", 128'(bus.rsp_valid), 128'(0));
        end
        checkVal("mid.busy", 128'(busy), 128'(0));
        checkVal("mid.stats", 128'(statOps), 128'(0));
        applyStimulus(4'b1111, 4'b1111, 1'b0);
        stepCycle("mid.first");
        checkVal("mid.firstGrant", 128'(lastReady), 128'(4'b0001));

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            randomOps();
            applyStimulus(NREQ'($urandom), NREQ'($urandom), ($urandom_range(0, 99) == 0));
            stepCycle("rand");
        end

        $display("[TB] stats");
        applyStimulus('0, '1, 1'b1);
        stepCycle("stats.rst");
        applyStimulus(4'b1111, 4'b1111, 1'b0);
        acc = 0;
        guard = 0;
        while (acc < 10 && guard < 100) begin
            randomOps();
            stepCycle("stats");
            acc += $countones(lastReady);
            guard++;
        end
        applyStimulus(4'b0000, 4'b1111, 1'b0);
        stepCycle("stats.end");
        checkVal("stats.accepts", 128'(acc), 128'(10));
`ifdef MULT_ARB_STATS_EN
        checkVal("stats.count", 128'(statOps), 128'(10));
`else
        checkVal("stats.count", 128'(statOps), 128'(0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
